pingpong_frame_buffer: RTL and testbench
========================================

# pingpong_frame_buffer

Single-clock, parametrised ping-pong frame buffer between the audio sample stream and the spectrum (FFT) reader. Incoming samples fill one bank with an internal write counter. The full bank is handed to the reader with a ready/done handshake while the other bank fills. Bank swap, ownership tracking and overflow detection are done inside the block, so upstream and downstream logic no longer steer bank selects or write addresses.

## Interface
- DATA_BITS, 16, sample width
- ADDR_BITS, 10, log2 of bank depth; DEPTH = 2**ADDR_BITS samples per frame
- clk  in  1  single clock for all logic and both banks
- rst  in  1  asynchronous, active-high reset
- wr_valid_i  in  1  sample strobe; one sample accepted per cycle when high
- wr_data_i  in  DATA_BITS  sample data
- wr_level_o  out  ADDR_BITS+1  samples written into current fill bank (0..DEPTH)
- frame_ready_o  out  1  level; a full bank is owned by the reader
- frame_done_o  out  1  one-cycle pulse on every bank swap
- rd_bank_o  out  1  index of bank currently readable
- rd_en_i  in  1  read strobe
- rd_addr_i  in  ADDR_BITS  read address within readable bank
- rd_data_o  out  DATA_BITS  registered read data
- rd_valid_o  out  1  rd_data_o valid this cycle
- rd_done_i  in  1  pulse; reader releases its bank
- overflow_o  out  1  one-cycle pulse per dropped sample
- drop_cnt_o  out  16  saturating dropped-sample count (only with PPFB_DROP_CNT_EN)

## Operation
- Registers: wr_bank (fill bank), wr_addr, held (reader owns bank ~wr_bank), state in {FILL, STALL}.
- rd_bank_o = ~wr_bank. frame_ready_o = held.
- FILL, wr_valid_i=1: write wr_data_i to bank wr_bank at wr_addr; wr_addr increments.
  - If not the last slot, no other action.
  - Last slot (wr_addr = DEPTH-1) with held=0 (after rd_done_i this cycle is applied): swap. wr_bank flips, wr_addr becomes 0, held becomes 1, frame_done_o pulses. State stays FILL.
  - Last slot with held=1: go to STALL. wr_level_o stays DEPTH.
- STALL: the fill bank is full and the reader still owns the other bank.
  - Each wr_valid_i sample is dropped: no RAM write, overflow_o pulses.
  - On rd_done_i: swap as above (held stays 1, rd_bank_o flips, frame_done_o pulses). Return to FILL with wr_addr=0. A sample arriving in the same cycle is dropped.
- rd_done_i with held=0 is ignored. rd_done_i in FILL clears held.
- Reads:
  - rd_en_i with held=1 reads bank rd_bank_o at rd_addr_i.
  - rd_en_i with held=0 is ignored: rd_valid_o=0, rd_data_o holds.
- Read and write never touch the same bank, so there is no address collision rule.
- Arithmetic: wr_addr is ADDR_BITS wide and wraps naturally on swap. wr_level_o = {full_flag, wr_addr}.

## Timing
- Reset values: frame_ready_o=0, frame_done_o=0, rd_bank_o=1 (wr_bank=0), rd_data_o=0, rd_valid_o=0, overflow_o=0, wr_level_o=0, drop_cnt_o=0. State is FILL.
- RAM contents are not reset.
- Write: sample at edge n lands in RAM at edge n; wr_level_o updates at n+1.
- Swap: DEPTH-th sample accepted at edge n. At n+1, frame_ready_o=1, rd_bank_o flipped, frame_done_o=1 for exactly one cycle.
- Read latency: rd_en_i at edge n gives rd_data_o and rd_valid_o=1 at n+1. Back-to-back reads sustain one per cycle.
- Release: rd_done_i at edge n gives frame_ready_o=0 at n+1 (FILL), or a swap visible at n+1 (STALL).
- Simultaneous last write and rd_done_i: release applies first, so the swap occurs and there is no STALL.
- Reset mid-frame discards the partial frame and ownership. The first post-reset sample goes to bank 0, address 0.

## Configuration
- PPFB_DROP_CNT_EN defined: drop_cnt_o exists. It increments on each overflow_o pulse, saturates at 0xFFFF, and clears only on rst.
- Not defined: port and counter absent. overflow_o behaviour is unchanged.

## Structure
- Package pingpong_frame_pkg holds the default DATA_BITS/ADDR_BITS constants, the FILL/STALL state enum, and the drop counter width (16).
- Sub-module pingpong_bank_ram, instantiated twice: simple dual-port, one clock, write port plus registered read port with read enable. It must infer block RAM.

## Test plan
Bench uses ADDR_BITS=3 (DEPTH=8), DATA_BITS=16.
- Reset, then 8 samples 0x0001..0x0008 on consecutive cycles -> frame_done_o pulses one cycle after the 8th; frame_ready_o=1; rd_bank_o=0; wr_level_o=0.
- Read addresses 0..7 back-to-back -> rd_data_o = 0x0001..0x0008 one cycle after each rd_en_i, with rd_valid_o high for 8 cycles.
- Second frame written while reader holds bank 0, no rd_done_i, then 3 extra samples -> wr_level_o=8; 3 overflow_o pulses; drop_cnt_o=3 with PPFB_DROP_CNT_EN; nothing written.
- rd_done_i in STALL -> next cycle rd_bank_o=1, frame_ready_o stays 1, frame_done_o pulses, wr_level_o=0; reading bank 1 returns the second frame intact.
- rd_done_i in the same cycle as the 8th sample -> swap with no STALL and no overflow_o; rd_done_i with frame_ready_o=0 is ignored.
- rst asserted after 5 samples -> all outputs at reset values immediately; next 8 samples form a clean frame in bank 0.

Source files
------------

// File: rtl/pingpong_frame_pkg.sv
// pingpong_frame_pkg
//
// Shared definitions for the ping-pong frame buffer:
//   PPFB_DATA_BITS  default sample width
//   PPFB_ADDR_BITS  default log2 of bank depth
//   DROP_CNT_BITS   width of the optional dropped-sample counter
//   ppfb_state_t    fill-side state (FILL / STALL)
package pingpong_frame_pkg;

  localparam int PPFB_DATA_BITS = 16;
  localparam int PPFB_ADDR_BITS = 10;
  localparam int DROP_CNT_BITS  = 16;

  // FILL: samples are being written into the fill bank.
  // STALL: fill bank is full and the reader still owns the other bank,
  //        so incoming samples are dropped until the reader releases.
  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } ppfb_state_t;

endpackage

// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram
//
// Simple dual-port RAM for one frame bank. Single clock, one write port and
// one registered read port with read enable. The read register only updates
// when re is high, so the last read value is held otherwise. No reset on the
// storage or the read register so that synthesis maps it onto block RAM.
//
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable
//   raddr  read address
//   rdata  registered read data (valid one cycle after re)
module pingpong_bank_ram #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer
//
// Ping-pong frame buffer between the audio sample stream and the FFT reader.
// Samples fill one bank using an internal write counter; a full bank is
// handed to the reader (frame_ready_o) while the other bank fills. Bank swap,
// ownership and overflow detection are handled here.
//
// Optional feature: define PPFB_DROP_CNT_EN to add drop_cnt_o, a saturating
// count of dropped samples (cleared only by rst).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_valid_i      sample strobe
//   wr_data_i       sample data
//   wr_level_o      samples in current fill bank (0..DEPTH)
//   frame_ready_o   reader owns a full bank
//   frame_done_o    one-cycle pulse on every bank swap
//   rd_bank_o       bank currently readable
//   rd_en_i         read strobe
//   rd_addr_i       read address within readable bank
//   rd_data_o       registered read data
//   rd_valid_o      rd_data_o valid this cycle
//   rd_done_i       reader releases its bank
//   overflow_o      one-cycle pulse per dropped sample
//   drop_cnt_o      dropped-sample count (PPFB_DROP_CNT_EN only)
module pingpong_frame_buffer
  import pingpong_frame_pkg::*;
#(
  parameter int DATA_BITS = PPFB_DATA_BITS,
  parameter int ADDR_BITS = PPFB_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  output logic [ADDR_BITS:0]   wr_level_o,
  output logic                 frame_ready_o,
  output logic                 frame_done_o,
  output logic                 rd_bank_o,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_done_i,
  output logic                 overflow_o
`ifdef PPFB_DROP_CNT_EN
  ,
  output logic [DROP_CNT_BITS-1:0] drop_cnt_o
`endif
);

  ppfb_state_t          state;
  logic                 wr_bank;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 held;
  logic                 full_flag;
  logic                 rd_sel;
  logic                 rd_seen;

  logic                 wr_en;
  logic                 rd_go;
  logic                 last_slot;
  logic                 held_after_release;
  logic                 drop_now;
  logic [DATA_BITS-1:0] q0;
  logic [DATA_BITS-1:0] q1;

  // Writes only happen in FILL; the read side only ever touches ~wr_bank,
  // so the two ports never address the same bank.
  assign wr_en              = (state == FILL) && wr_valid_i;
  assign rd_go              = rd_en_i && held;
  assign last_slot          = &wr_addr;
  // A release in the same cycle as the last write is applied first.
  assign held_after_release = held && !rd_done_i;
  assign drop_now           = (state == STALL) && wr_valid_i;

  pingpong_bank_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_bank0 (
    .clk  (clk),
    .we   (wr_en && !wr_bank),
    .waddr(wr_addr),
    .wdata(wr_data_i),
    .re   (rd_go && wr_bank),
    .raddr(rd_addr_i),
    .rdata(q0)
  );

  pingpong_bank_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_bank1 (
    .clk  (clk),
    .we   (wr_en && wr_bank),
    .waddr(wr_addr),
    .wdata(wr_data_i),
    .re   (rd_go && !wr_bank),
    .raddr(rd_addr_i),
    .rdata(q1)
  );

  // Fill/ownership FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      wr_bank      <= 1'b0;
      wr_addr      <= '0;
      held         <= 1'b0;
      full_flag    <= 1'b0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_sel       <= 1'b0;
      rd_seen      <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      overflow_o   <= drop_now;
      rd_valid_o   <= rd_go;

      // Remember which bank's read register drives rd_data_o; it holds
      // its last value while no read is issued.
      if (rd_go) begin
        rd_sel  <= ~wr_bank;
        rd_seen <= 1'b1;
      end

      case (state)
        FILL: begin
          if (wr_valid_i) begin
            wr_addr <= wr_addr + ADDR_BITS'(1);
            if (last_slot) begin
              if (!held_after_release) begin
                wr_bank      <= ~wr_bank;
                held         <= 1'b1;
                frame_done_o <= 1'b1;
              end else begin
                state     <= STALL;
                full_flag <= 1'b1;
              end
            end else if (rd_done_i) begin
              held <= 1'b0;
            end
          end else if (rd_done_i) begin
            held <= 1'b0;
          end
        end
        STALL: begin
          // wr_addr already wrapped to 0 on the last write; ownership
          // passes straight to the freshly filled bank.
          if (rd_done_i) begin
            state        <= FILL;
            wr_bank      <= ~wr_bank;
            wr_addr      <= '0;
            full_flag    <= 1'b0;
            held         <= 1'b1;
            frame_done_o <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef PPFB_DROP_CNT_EN
  // Saturating dropped-sample counter, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o <= '0;
    end else if (drop_now && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + DROP_CNT_BITS'(1);
    end
  end
`endif

  assign wr_level_o    = {full_flag, wr_addr};
  assign frame_ready_o = held;
  assign rd_bank_o     = ~wr_bank;
  // Bank read registers are not reset, so present zero until the first read.
  assign rd_data_o     = rd_seen ? (rd_sel ? q1 : q0) : '0;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// tb_pingpong_frame_buffer
//
// Directed bench for pingpong_frame_buffer with DEPTH=8, DATA_BITS=16.
// Inputs change 1 time unit after the rising edge; outputs are checked
// in the same window, after the edge that sampled the stimulus.
module tb_pingpong_frame_buffer;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          wr_valid_i;
  logic [DW-1:0] wr_data_i;
  logic [AW:0]   wr_level_o;
  logic          frame_ready_o;
  logic          frame_done_o;
  logic          rd_bank_o;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_done_i;
  logic          overflow_o;
`ifdef PPFB_DROP_CNT_EN
  logic [15:0]   drop_cnt_o;
`endif

  int vectors    = 0;
  int miscompares = 0;

  pingpong_frame_buffer #(
    .DATA_BITS(DW),
    .ADDR_BITS(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_level_o   (wr_level_o),
    .frame_ready_o(frame_ready_o),
    .frame_done_o (frame_done_o),
    .rd_bank_o    (rd_bank_o),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .rd_done_i    (rd_done_i),
    .overflow_o   (overflow_o)
`ifdef PPFB_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                input logic re, input logic [AW-1:0] ra,
                                input logic done);
    wr_valid_i = v;
    wr_data_i  = d;
    rd_en_i    = re;
    rd_addr_i  = ra;
    rd_done_i  = done;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_level"}, 32'(wr_level_o), 0);
    check_output({tag, "_ready"}, 32'(frame_ready_o), 0);
    check_output({tag, "_done"}, 32'(frame_done_o), 0);
    check_output({tag, "_rdbank"}, 32'(rd_bank_o), 1);
    check_output({tag, "_rddata"}, 32'(rd_data_o), 0);
    check_output({tag, "_rdvalid"}, 32'(rd_valid_o), 0);
    check_output({tag, "_ovf"}, 32'(overflow_o), 0);
`ifdef PPFB_DROP_CNT_EN
    check_output({tag, "_dropcnt"}, 32'(drop_cnt_o), 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0);
    #3;
    $display("[TB] reset state");
    check_reset_values("rst");
    tick();
    tick();
    rst = 1'b0;

    // Frame 1: 0x0001..0x0008 into bank 0.
    $display("[TB] frame 1 fill");
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1, DW'(i), 0, 0, 0);
      tick();
      if (i < 8) begin
        check_output("f1_level", 32'(wr_level_o), 32'(i));
        check_output("f1_done_early", 32'(frame_done_o), 0);
      end
    end
    check_output("f1_done", 32'(frame_done_o), 1);
    check_output("f1_ready", 32'(frame_ready_o), 1);
    check_output("f1_rdbank", 32'(rd_bank_o), 0);
    check_output("f1_level_wrap", 32'(wr_level_o), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    tick();
    check_output("f1_done_pulse", 32'(frame_done_o), 0);

    // Back-to-back reads of bank 0.
    $display("[TB] frame 1 readback");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 1, AW'(i), 0);
      tick();
      check_output("f1_rddata", 32'(rd_data_o), 32'(i + 1));
      check_output("f1_rdvalid", 32'(rd_valid_o), 1);
    end
    apply_stimulus(0, 0, 0, 0, 0);
    tick();
    check_output("f1_rdvalid_off", 32'(rd_valid_o), 0);
    check_output("f1_rddata_hold", 32'(rd_data_o), 32'h8);

    // Frame 2 into bank 1 while reader still holds bank 0 -> STALL.
    $display("[TB] frame 2 fill and stall");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, DW'(16'h0011 + i), 0, 0, 0);
      tick();
    end
    check_output("f2_level_full", 32'(wr_level_o), 8);
    check_output("f2_no_done", 32'(frame_done_o), 0);
    check_output("f2_ovf_none", 32'(overflow_o), 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 16'hDEAD, 0, 0, 0);
      tick();
      check_output("stall_ovf", 32'(overflow_o), 1);
      check_output("stall_level", 32'(wr_level_o), 8);
    end
    apply_stimulus(0, 0, 1, 3'd3, 0);
    tick();
    check_output("stall_ovf_off", 32'(overflow_o), 0);
    check_output("stall_read_b0", 32'(rd_data_o), 32'h4);
`ifdef PPFB_DROP_CNT_EN
    check_output("stall_dropcnt", 32'(drop_cnt_o), 3);
`endif

    // Release in STALL -> swap to bank 1.
    $display("[TB] release in stall");
    apply_stimulus(0, 0, 0, 0, 1);
    tick();
    check_output("rel_rdbank", 32'(rd_bank_o), 1);
    check_output("rel_ready", 32'(frame_ready_o), 1);
    check_output("rel_done", 32'(frame_done_o), 1);
    check_output("rel_level", 32'(wr_level_o), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    tick();
    check_output("rel_done_pulse", 32'(frame_done_o), 0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 1, AW'(i), 0);
      tick();
      check_output("f2_rddata", 32'(rd_data_o), 32'(16'h0011 + i));
    end

    // Frame 3 into bank 0 with release on the last sample -> no STALL.
    $display("[TB] release with last sample");
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1, DW'(16'h0021 + i), 0, 0, 0);
      tick();
    end
    apply_stimulus(1, 16'h0028, 0, 0, 1);
    tick();
    check_output("f3_done", 32'(frame_done_o), 1);
    check_output("f3_ready", 32'(frame_ready_o), 1);
    check_output("f3_rdbank", 32'(rd_bank_o), 0);
    check_output("f3_level", 32'(wr_level_o), 0);
    check_output("f3_ovf", 32'(overflow_o), 0);
    apply_stimulus(1, 16'h0031, 1, 3'd7, 0);
    tick();
    check_output("f3_ovf_next", 32'(overflow_o), 0);
    check_output("f3_rddata", 32'(rd_data_o), 32'h28);
    check_output("f3_level_next", 32'(wr_level_o), 1);

    // Release in FILL, then a release and a read with nothing held.
    apply_stimulus(0, 0, 0, 0, 1);
    tick();
    check_output("fill_rel_ready", 32'(frame_ready_o), 0);
    apply_stimulus(0, 0, 1, 3'd2, 1);
    tick();
    check_output("idle_rel_ready", 32'(frame_ready_o), 0);
    check_output("idle_rel_done", 32'(frame_done_o), 0);
    check_output("idle_rel_rdbank", 32'(rd_bank_o), 0);
    check_output("idle_rd_valid", 32'(rd_valid_o), 0);
    check_output("idle_rd_hold", 32'(rd_data_o), 32'h28);

    // Four more samples (five total in bank 1), then reset mid-frame.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, DW'(16'h0032 + i), 0, 0, 0);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("pre_rst_level", 32'(wr_level_o), 5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, DW'(16'h0041 + i), 0, 0, 0);
      tick();
    end
    check_output("f4_done", 32'(frame_done_o), 1);
    check_output("f4_rdbank", 32'(rd_bank_o), 0);
    check_output("f4_ready", 32'(frame_ready_o), 1);
    apply_stimulus(0, 0, 1, 3'd0, 0);
    tick();
    check_output("f4_rd0", 32'(rd_data_o), 32'h41);
    apply_stimulus(0, 0, 1, 3'd7, 0);
    tick();
    check_output("f4_rd7", 32'(rd_data_o), 32'h48);
    apply_stimulus(0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
